// File: rtl/bank_pkg.sv
// bank_pkg
// Shared definitions for the data bank and its arbiter: default geometry,
// requester index constants and a clog2 helper for sizing registers.
// No ports; imported with "import bank_pkg::*;".
package bank_pkg;

  // Default bank geometry: three requesters, 512 words of 128 bits.
  localparam int DEF_NREQ = 3;
  localparam int DEF_AW   = 9;
  localparam int DEF_DW   = 128;

  // Conventional requester slots.
  localparam int REQ_IC   = 0;
  localparam int REQ_MVU  = 1;
  localparam int REQ_CTRL = 2;

  // Number of bits needed to index 'value' items (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bank_rr_arb.sv
// bank_rr_arb
// Single-winner arbiter for the data bank. Produces a one-hot (or zero)
// grant combinationally from the request vector and the priority pointer.
// Build option: BANK_ARB_RR_EN defined -> round-robin pointer that moves to
// the requester after the last winner; undefined -> fixed priority, index 0
// highest, and no pointer register exists.
// Ports:
//   clk   in  1     clock
//   rst   in  1     synchronous active-high reset (pointer back to 0)
//   req   in  NREQ  per-requester request
//   grnt  out NREQ  one-hot or zero grant
module bank_rr_arb
  import bank_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grnt
);

  localparam int PW = (NREQ > 1) ? clog2(NREQ) : 1;

`ifdef BANK_ARB_RR_EN

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     nxt;
  logic [2*NREQ-1:0] rot;
  logic              hit;
  int                off;
  int                gsum;

  // Rotate the requests so the pointer's requester sits at bit 0, take the
  // lowest set bit, then map that offset back to an absolute index.
  always_comb begin
    rot  = {req, req} >> ptr;
    hit  = 1'b0;
    off  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        hit = 1'b1;
        off = k;
      end
    end
    gsum = int'(ptr) + off;
    if (gsum >= NREQ) begin
      gsum = gsum - NREQ;
    end
    grnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (hit && (gsum == i)) begin
        grnt[i] = 1'b1;
      end
    end
    nxt = (gsum == NREQ - 1) ? '0 : PW'(gsum + 1);
  end

  // The pointer only moves when somebody was granted; idle cycles keep it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= nxt;
    end
  end

`else

  logic taken;

  // Fixed priority: lowest index wins.
  always_comb begin
    grnt  = '0;
    taken = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !taken) begin
        grnt[i] = 1'b1;
        taken   = 1'b1;
      end
    end
  end

  // Clock and reset have no state to drive in the fixed-priority build.
  logic unused_clkrst;
  assign unused_clkrst = clk ^ rst;

`endif

endmodule

// File: rtl/bank_arb.sv
// bank_arb
// N-requester single-port data bank: arbitrates one access per cycle,
// issues it to the BRAM in the grant cycle, and returns read data through a
// RDLAT-deep tagged pipeline so each requester sees its own rvalid strobe.
// Build option: BANK_ARB_RR_EN selects round-robin priority (see
// bank_rr_arb); undefined gives fixed priority with index 0 highest.
// Ports:
//   clk    in  1        clock
//   rst    in  1        synchronous active-high reset
//   req    in  NREQ     per-requester request
//   we     in  NREQ     per-requester write enable, qualifies req
//   addr   in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//   wdata  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
//   grnt   out NREQ     one-hot or zero grant (combinational)
//   rvalid out NREQ     one-hot read-return strobe
//   rdata  out DW       read data, valid while any rvalid bit is set
module bank_arb
  import bank_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int RDLAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    grnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata
);

  logic [AW-1:0]   maddr;
  logic [DW-1:0]   mwdata;
  logic            wsel;
  logic            men;
  logic            mwe;
  logic [NREQ-1:0] rtag;

  logic [DW-1:0]   mem   [0:(1<<AW)-1];
  logic [NREQ-1:0] vpipe [RDLAT];
  logic [DW-1:0]   dpipe [RDLAT];

  bank_rr_arb #(
    .NREQ (NREQ)
  ) arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .grnt (grnt)
  );

  // Steer the winner onto the memory port. Because the grant is one-hot,
  // OR-ing masked fields is a mux that also yields zeros when idle. Reset
  // blocks the memory enable so a grant shown in a reset cycle does nothing.
  always_comb begin
    maddr  = '0;
    mwdata = '0;
    wsel   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grnt[i]) begin
        maddr  = maddr | addr[i*AW +: AW];
        mwdata = mwdata | wdata[i*DW +: DW];
        wsel   = wsel | we[i];
      end
    end
    men  = (|grnt) & ~rst;
    mwe  = men & wsel;
    rtag = rst ? '0 : (grnt & ~we);
  end

  // BRAM write port.
  always_ff @(posedge clk) begin
    if (mwe) begin
      mem[maddr] <= mwdata;
    end
  end

  // Read-return pipeline. Stage 0 is the BRAM output register, loaded only on
  // reads; later stages advance only behind a valid tag, so the data seen on
  // rdata changes only in the cycle its rvalid is high and holds otherwise.
  // A write committed on the previous edge is already in the array, so a
  // read on the next cycle returns the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RDLAT; k++) begin
        vpipe[k] <= '0;
        dpipe[k] <= '0;
      end
    end else begin
      vpipe[0] <= rtag;
      if (men && !mwe) begin
        dpipe[0] <= mem[maddr];
      end
      for (int k = 1; k < RDLAT; k++) begin
        vpipe[k] <= vpipe[k-1];
        if (|vpipe[k-1]) begin
          dpipe[k] <= dpipe[k-1];
        end
      end
    end
  end

  assign rvalid = vpipe[RDLAT-1];
  assign rdata  = dpipe[RDLAT-1];

endmodule

// File: tb/tb_bank_arb.sv
// tb_bank_arb
// Scoreboarded bench for bank_arb: a driver issues accesses and records the
// expected read returns from a word-array model of the bank; a monitor pops
// and compares them whenever rvalid is raised.
module tb_bank_arb;

  localparam int NREQ  = 3;
  localparam int AW    = 9;
  localparam int DW    = 128;
  localparam int RDLAT = 2;

  typedef struct {
    logic [NREQ-1:0] tag;
    logic [DW-1:0]   data;
    int              due;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    we = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0]    grnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;

  logic               preq   [NREQ];
  logic               pwe    [NREQ];
  logic [AW-1:0]      paddr  [NREQ];
  logic [DW-1:0]      pwdata [NREQ];

  logic [DW-1:0]      mdl [0:(1<<AW)-1];
  int                 mptr = 0;
  exp_t               sb[$];
  logic [DW-1:0]      held = '0;
  int                 edgecnt = 0;
  bit                 enabled = 1'b0;
  int                 nchecks = 0;
  int                 nfails = 0;

  bank_arb #(
    .NREQ  (NREQ),
    .AW    (AW),
    .DW    (DW),
    .RDLAT (RDLAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .grnt   (grnt),
    .rvalid (rvalid),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfails++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edgecnt);
    end
  endtask

  // Requester chosen by the arbitration rule: first pending one at or after
  // the priority pointer, wrapping around.
  function automatic int pickGrant(input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (preq[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Drive one cycle from the pending table, check the grant, then advance
  // the model at the clock edge.
  task automatic applyStimulus(input logic rstv);
    int g;
    logic [NREQ-1:0] expg;
    rst = rstv;
    for (int i = 0; i < NREQ; i++) begin
      req[i]               = preq[i];
      we[i]                = pwe[i];
      addr[i*AW +: AW]     = paddr[i];
      wdata[i*DW +: DW]    = pwdata[i];
    end
    #1;
    g    = pickGrant(mptr);
    expg = (g >= 0) ? NREQ'(1 << g) : '0;
    if (enabled) checkOutput("grnt", DW'(grnt), DW'(expg));
    @(posedge clk);
    edgecnt++;
    if (rstv) begin
      mptr = 0;
      sb.delete();
      held = '0;
    end else if (g >= 0) begin
      if (pwe[g]) begin
        mdl[paddr[g]] = pwdata[g];
      end else begin
        sb.push_back('{tag: expg, data: mdl[paddr[g]], due: edgecnt + RDLAT - 1});
      end
`ifdef BANK_ARB_RR_EN
      mptr = (g + 1) % NREQ;
`endif
      preq[g] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic doOp(input int r, input logic w, input int a, input logic [DW-1:0] d);
    preq[r]   = 1'b1;
    pwe[r]    = w;
    paddr[r]  = AW'(a);
    pwdata[r] = d;
    applyStimulus(1'b0);
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every rvalid must match the oldest outstanding read, on time;
  // between returns rdata must hold the last returned word.
  always @(negedge clk) begin
    exp_t e;
    if (enabled) begin
      if (rvalid != '0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rvalid", DW'(rvalid), '0);
        end else begin
          e = sb.pop_front();
          checkOutput("rvalid_tag", DW'(rvalid), DW'(e.tag));
          checkOutput("rdata", rdata, e.data);
          checkOutput("rvalid_edge", DW'(edgecnt), DW'(e.due));
          held = e.data;
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= edgecnt) begin
          e = sb.pop_front();
          checkOutput("missing_rvalid", DW'(rvalid), DW'(e.tag));
        end
        checkOutput("rdata_hold", rdata, held);
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      preq[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
    end
    @(negedge clk);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    enabled = 1'b1;
    applyStimulus(1'b0);
    checkOutput("reset_rvalid", DW'(rvalid), '0);
    checkOutput("reset_rdata", rdata, '0);

    // Basic write then read from another requester.
    doOp(0, 1'b1, 5, {16{8'hA5}});
    doOp(2, 1'b0, 5, '0);
    for (int c = 0; c < RDLAT + 1; c++) applyStimulus(1'b0);

    // Preload the random-test window, then the three directed words.
    for (int a = 0; a < 32; a++) doOp(a % NREQ, 1'b1, a, rnd128());
    doOp(0, 1'b1, 1, DW'(8'h11));
    doOp(1, 1'b1, 2, DW'(8'h22));
    doOp(2, 1'b1, 3, DW'(8'h33));

    // All three requesting continuously for six cycles.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        preq[i] = 1'b1; pwe[i] = 1'b0; paddr[i] = AW'(i + 1);
      end
      applyStimulus(1'b0);
    end
    for (int i = 0; i < NREQ; i++) preq[i] = 1'b0;
    for (int c = 0; c < RDLAT + 1; c++) applyStimulus(1'b0);

    // Back-to-back reads from different requesters.
    doOp(0, 1'b0, 1, '0);
    doOp(1, 1'b0, 2, '0);
    doOp(2, 1'b0, 3, '0);
    for (int c = 0; c < RDLAT + 1; c++) applyStimulus(1'b0);

    // Read immediately after write to the same address.
    doOp(1, 1'b1, 9, DW'(8'h77));
    doOp(2, 1'b0, 9, '0);
    for (int c = 0; c < RDLAT + 1; c++) applyStimulus(1'b0);

    // Reset one cycle after a read: the read must never return.
    doOp(1, 1'b0, 5, '0);
    applyStimulus(1'b1);
    for (int c = 0; c < RDLAT + 1; c++) applyStimulus(1'b0);
    checkOutput("post_reset_rvalid", DW'(rvalid), '0);
    checkOutput("post_reset_rdata", rdata, '0);
    for (int i = 0; i < NREQ; i++) begin
      preq[i] = 1'b1; pwe[i] = 1'b0; paddr[i] = AW'(i + 1);
    end
    applyStimulus(1'b0);
    for (int i = 0; i < NREQ; i++) preq[i] = 1'b0;
    for (int c = 0; c < RDLAT + 1; c++) applyStimulus(1'b0);

    // Idle: no grants, rdata holds.
    for (int c = 0; c < 4; c++) applyStimulus(1'b0);

    // Random traffic; an ungranted request stays pending unchanged.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!preq[i] && ($urandom_range(0, 1) == 1)) begin
          preq[i]   = 1'b1;
          pwe[i]    = ($urandom_range(0, 2) == 0);
          paddr[i]  = AW'($urandom_range(0, 31));
          pwdata[i] = rnd128();
        end
      end
      applyStimulus(1'b0);
    end

    // Drain outstanding work.
    for (int c = 0; c < 20 && (sb.size() != 0 || preq[0] || preq[1] || preq[2]); c++) begin
      applyStimulus(1'b0);
    end
    for (int c = 0; c < RDLAT + 1; c++) applyStimulus(1'b0);
    checkOutput("drain_outstanding", DW'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
    $finish;
  end

endmodule

// File: doc/bank_arb.md
# bank_arb

Parametrised successor to the fixed three-port 128-bit data bank. It is an N-requester, single-port BRAM bank with a registered arbiter, write enables, and a tagged read-return pipeline, so each requester knows exactly when its read data is valid. It sits between the IC, MVU and control masters and one bank of on-chip memory, and replaces the hard-wired fixed-priority mux.

## Interface
Parameters:
- NREQ, 3: number of requesters (≥2); index 0 is IC, 1 is MVU, 2 is Ctrl by convention.
- AW, 9: address width (depth = 2^AW words).
- DW, 128: data word width.
- RDLAT, 1: read latency in cycles from grant to rvalid (≥1); 1 = bare BRAM, each extra is one output register stage.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester access request.
- we  in  NREQ  per-requester write enable; qualifies req.
- addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data; requester i at [i*DW +: DW].
- grnt  out  NREQ  one-hot (or zero) grant, combinational from req and priority state.
- rvalid  out  NREQ  one-hot read-return strobe.
- rdata  out  DW  read data, valid when any rvalid bit is high.

## Operation
- Exactly one requester is granted per cycle when any req is high. The granted access (read or write) is issued to memory in that same cycle. Ungranted requesters must hold req/we/addr/wdata stable and retry.
- With no req, memory enable and write enable are both 0. Address and data are driven 0, never X.
- Priority: a pointer register ptr (log2 NREQ bits). The highest-priority requester is ptr, then ptr+1, … mod NREQ.
- After any grant to i, ptr ← (i+1) mod NREQ. With no grant, ptr holds.
- Write (we[i]=1 while granted): memory word addr_i ← wdata_i at the clock edge. No rvalid is produced.
- Read (we[i]=0 while granted): the tag (one-hot i) enters a RDLAT-deep valid shift pipeline. rvalid equals the pipeline tail.
- rdata is registered. It updates only in the cycle its rvalid is high and holds its last value otherwise.
- Read-after-write to the same address in consecutive cycles returns the new data (BRAM read-first is not allowed across cycles). A same-cycle conflict is impossible because the bank is single-issue.
- Back-to-back reads from different requesters pipeline fully: one rvalid per cycle, in grant order.

## Timing
- Reset: ptr=0, valid pipeline cleared, rvalid=0, rdata=0. grnt follows req with ptr=0, i.e. requester 0 has highest priority.
- Reset asserted mid-operation: in-flight reads are dropped and produce no rvalid. A grant shown in the reset cycle has no memory effect (write enable is gated by ~rst).
- Read latency: grant on edge N gives rvalid/rdata valid during cycle N+RDLAT.
- Throughput: 1 access per cycle. The worst-case wait for a requester holding req is NREQ-1 cycles.

## Configuration
- BANK_ARB_RR_EN defined: round-robin pointer behaviour as above.
- BANK_ARB_RR_EN undefined: ptr is removed and priority is fixed with index 0 highest. This reproduces the legacy IC > MVU > Ctrl order.
- All other behaviour is identical in both builds.

## Structure
- Shared package bank_pkg holds:
  - default AW/DW/NREQ constants;
  - requester index constants (REQ_IC=0, REQ_MVU=1, REQ_CTRL=2);
  - the clog2 helper function.
- Sub-module bank_rr_arb contains the pointer register and the one-hot grant logic (req, ptr → grnt), which keeps it unit-testable.
- Memory is the existing single-port BRAM primitive, driven with its write-enable input.

## Test plan
- Reset, then write 0xA5…A5 to address 5 from requester 0, then read address 5 from requester 2 → grnt=3'b100 on the read, rvalid=3'b100 exactly RDLAT cycles later, rdata=0xA5…A5.
- req=3'b111 held for 6 cycles with RR_EN → grnt sequence 001,010,100,001,010,100. Without RR_EN → 001 every cycle.
- Reads from requesters 0,1,2 on consecutive cycles to addresses 1,2,3 preloaded with 0x11,0x22,0x33 → rvalid 001,010,100 on consecutive cycles with matching rdata.
- Write 0x77 to address 9 on cycle N, read address 9 on cycle N+1 → rdata=0x77.
- Read issued, then rst asserted 1 cycle later (RDLAT=2) → no rvalid, rdata=0, ptr=0 after release.
- req=0 for 4 cycles → grnt=0, rvalid=0, memory enable low, ptr unchanged, rdata holds.
